// File: rtl/cntdn_pkg.sv
// Shared types, segment codes and digit helpers for the countdown timer.
package cntdn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_N     = 8'hAB;
  localparam logic [7:0] SEG_D     = 8'hA1;

  // Digits 1 and 3 hold tens of seconds/minutes when hh:mm:ss mode is on
  function automatic logic [3:0] digit_radix(input int unsigned index, input logic hms);
    logic [3:0] r;
    r = 4'd10;
    if (hms && (index == 1 || index == 3)) r = 4'd6;
    return r;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0: s = SEG_0;
      4'd1: s = SEG_1;
      4'd2: s = SEG_2;
      4'd3: s = SEG_3;
      4'd4: s = SEG_4;
      4'd5: s = SEG_5;
      4'd6: s = SEG_6;
      4'd7: s = SEG_7;
      4'd8: s = SEG_8;
      4'd9: s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key debouncer: emits a 1-cycle pulse on release after a long enough press.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] SAT = CW'(DEBOUNCE_CYC);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count while held (saturating); on release pulse only if saturated, then clear
  always_comb begin
    cnt_d = cnt_q;
    pulse = 1'b0;
    if (!key_n) begin
      if (cnt_q != SAT) cnt_d = cnt_q + CW'(1);
    end else begin
      pulse = (cnt_q == SAT);
      cnt_d = '0;
    end
  end

  // Press-duration counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cntdn_timer_mux.sv
// Countdown timer with multiplexed 7-segment display and five push keys.
// Optional pause in RUN is enabled by defining CNTDN_PAUSE_EN.
module cntdn_timer_mux
  import cntdn_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned HMS_MODE     = 1,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned TICK_CYC     = 50000000,
  parameter int unsigned SCAN_DIV     = 50000
) (
  input  logic                    clkin,
  input  logic                    rst,
  input  logic                    ke,
  input  logic                    ku,
  input  logic                    kd,
  input  logic                    kl,
  input  logic                    kr,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [7:0]              led,
  output logic                    alarm,
  output logic [4*NUM_DIGITS-1:0] value
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(TICK_CYC / 2);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic          HMS       = (HMS_MODE != 0);

  logic pe, pu, pd, pl, pr;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [IW-1:0]           cursor_q, cursor_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [SW-1:0]           scan_q;
  logic [IW-1:0]           idx_q;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]              led_q, seg_d;
  logic [3:0]              cur_digit;
`ifdef CNTDN_PAUSE_EN
  logic                    paused_q, paused_d;
  logic [TW-1:0]           blink_q;
`endif

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ke (.clk(clkin), .rst(rst), .key_n(ke), .pulse(pe));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ku (.clk(clkin), .rst(rst), .key_n(ku), .pulse(pu));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_kd (.clk(clkin), .rst(rst), .key_n(kd), .pulse(pd));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_kl (.clk(clkin), .rst(rst), .key_n(kl), .pulse(pl));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_kr (.clk(clkin), .rst(rst), .key_n(kr), .pulse(pr));

  // Increment or decrement one digit with wrap at its own radix
  function automatic logic [4*NUM_DIGITS-1:0] step_digit(
    input logic [4*NUM_DIGITS-1:0] v, input logic [IW-1:0] pos, input logic up);
    logic [4*NUM_DIGITS-1:0] r;
    logic [3:0] d, rad;
    r = v;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      d   = v[4*i +: 4];
      rad = digit_radix(i, HMS);
      if (IW'(i) == pos) begin
        if (up) r[4*i +: 4] = (d >= rad - 4'd1) ? 4'd0 : d + 4'd1;
        else    r[4*i +: 4] = (d == 4'd0) ? rad - 4'd1 : d - 4'd1;
      end
    end
    return r;
  endfunction

  // Subtract one from the whole count, borrowing through mixed radices
  function automatic logic [4*NUM_DIGITS-1:0] bcd_dec(input logic [4*NUM_DIGITS-1:0] v);
    logic [4*NUM_DIGITS-1:0] r;
    logic [3:0] d, rad;
    logic borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      d   = v[4*i +: 4];
      rad = digit_radix(i, HMS);
      if (borrow) begin
        if (d == 4'd0) r[4*i +: 4] = rad - 4'd1;
        else begin
          r[4*i +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state logic: key handling, countdown and tick counter
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    cursor_d = cursor_q;
    tick_d   = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
`ifdef CNTDN_PAUSE_EN
    paused_d = paused_q;
`endif
    case (state_q)
      IDLE: begin
        if (pe) begin
          state_d  = SET;
          value_d  = '0;
          cursor_d = '0;
        end
      end
      SET: begin
        if (pe) begin
          state_d = (value_q != '0) ? RUN : DONE;
        end else begin
          if (pu ^ pd) value_d = step_digit(value_q, cursor_q, pu);
          if (pl && !pr) cursor_d = (cursor_q == IDX_LAST) ? '0 : cursor_q + IW'(1);
          else if (pr && !pl) cursor_d = (cursor_q == '0) ? IDX_LAST : cursor_q - IW'(1);
        end
      end
      RUN: begin
        if (pe) begin
          state_d = DONE;
        end else begin
`ifdef CNTDN_PAUSE_EN
          if (pu) paused_d = !paused_q;
          if (paused_q) tick_d = tick_q;
          else if (tick_q == TICK_LAST) begin
`else
          if (tick_q == TICK_LAST) begin
`endif
            value_d = bcd_dec(value_q);
            if (value_d == '0) state_d = DONE;
          end
        end
      end
      DONE: begin
        if (pe) begin
          state_d = IDLE;
          value_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) tick_d = '0;
`ifdef CNTDN_PAUSE_EN
    if (state_d != RUN) paused_d = 1'b0;
`endif
  end

  // Control state registers
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q  <= IDLE;
      value_q  <= '0;
      cursor_q <= '0;
      tick_q   <= '0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      cursor_q <= cursor_d;
      tick_q   <= tick_d;
    end
  end

`ifdef CNTDN_PAUSE_EN
  // Pause flag plus a free-running blink timebase, since the tick counter freezes while paused
  always_ff @(posedge clkin) begin
    if (rst) begin
      paused_q <= 1'b0;
      blink_q  <= '0;
    end else begin
      paused_q <= paused_d;
      blink_q  <= (blink_q == TICK_LAST) ? '0 : blink_q + TW'(1);
    end
  end
`endif

  // Segment pattern and digit select for the currently scanned index
  always_comb begin
    cur_digit = '0;
    sel_d     = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        cur_digit = value_q[4*i +: 4];
        sel_d[i]  = 1'b0;
      end
    end
    seg_d = SEG_BLANK;
    case (state_q)
      IDLE: seg_d = SEG_0;
      SET: begin
        if (idx_q == cursor_q && tick_q >= TICK_HALF) seg_d = SEG_BLANK;
        else seg_d = seg_decode(cur_digit);
      end
      RUN: begin
        seg_d = seg_decode(cur_digit);
`ifdef CNTDN_PAUSE_EN
        if (paused_q && blink_q >= TICK_HALF) seg_d = SEG_BLANK;
`endif
      end
      DONE: begin
        if (idx_q == IW'(3))      seg_d = SEG_E;
        else if (idx_q == IW'(2)) seg_d = SEG_N;
        else if (idx_q == IW'(1)) seg_d = SEG_D;
        else                      seg_d = SEG_BLANK;
      end
      default: seg_d = SEG_BLANK;
    endcase
  end

  // Scan divider/index and registered display outputs
  always_ff @(posedge clkin) begin
    if (rst) begin
      scan_q <= '0;
      idx_q  <= '0;
      sel_q  <= '1;
      led_q  <= SEG_BLANK;
    end else begin
      scan_q <= (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
      if (scan_q == SCAN_LAST) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      sel_q  <= sel_d;
      led_q  <= seg_d;
    end
  end

  assign sel   = sel_q;
  assign led   = led_q;
  assign alarm = (state_q != DONE);
  assign value = value_q;

endmodule

// File: tb/tb_cntdn_timer_mux.sv
// Self-checking bench for cntdn_timer_mux with small timing parameters.
module tb_cntdn_timer_mux;
  import cntdn_pkg::*;

  localparam int ND = 6;
  localparam int DB = 4;
  localparam int TC = 10;
  localparam int SD = 2;

  localparam logic [4:0] M_E = 5'b00001;
  localparam logic [4:0] M_U = 5'b00010;
  localparam logic [4:0] M_D = 5'b00100;
  localparam logic [4:0] M_L = 5'b01000;
  localparam logic [4:0] M_R = 5'b10000;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        kn;
  logic [ND-1:0]     sel;
  logic [7:0]        led;
  logic              alarm;
  logic [4*ND-1:0]   value;

  typedef struct {
    logic [4:0]  keys;
    logic [23:0] value;
    logic [2:0]  cursor;
  } vec_t;

  typedef struct {
    logic [23:0] value;
    logic [2:0]  cursor;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   id;
  logic [7:0] el;
  logic [5:0] seen;

  always #5 clk = ~clk;

  cntdn_timer_mux #(
    .NUM_DIGITS(ND), .HMS_MODE(1), .DEBOUNCE_CYC(DB), .TICK_CYC(TC), .SCAN_DIV(SD)
  ) dut (
    .clkin(clk), .rst(rst),
    .ke(kn[0]), .ku(kn[1]), .kd(kn[2]), .kl(kn[3]), .kr(kn[4]),
    .sel(sel), .led(led), .alarm(alarm), .value(value)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] mask, input int low);
    kn = ~mask;
    tick(low);
    kn = '1;
    tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
    chk({tag, "_value"}, 32'(value), 32'h0);
    chk({tag, "_sel"},   32'(sel), 32'h3F);
    chk({tag, "_led"},   32'(led), 32'hFF);
    chk({tag, "_alarm"}, 32'(alarm), 32'h1);
  endtask

  initial begin
    // Editing vectors, all applied in SET starting from value 0, cursor 0
    for (int i = 0; i < 11; i++) tbl.push_back('{M_U, 24'((i + 1) % 10), 3'd0});
    tbl.push_back('{M_L,       24'h000001, 3'd1});
    tbl.push_back('{M_D,       24'h000051, 3'd1});
    tbl.push_back('{M_R,       24'h000051, 3'd0});
    tbl.push_back('{M_R,       24'h000051, 3'd5});
    tbl.push_back('{M_U | M_D, 24'h000051, 3'd5});
    tbl.push_back('{M_L | M_R, 24'h000051, 3'd5});
    tbl.push_back('{M_U,       24'h100051, 3'd5});
    tbl.push_back('{M_L,       24'h100051, 3'd0});
    tbl.push_back('{M_D,       24'h100050, 3'd0});
    tbl.push_back('{M_R,       24'h100050, 3'd5});
    tbl.push_back('{M_D,       24'h000050, 3'd5});
    tbl.push_back('{M_R,       24'h000050, 3'd4});
    tbl.push_back('{M_R,       24'h000050, 3'd3});
    tbl.push_back('{M_D,       24'h005050, 3'd3});
    tbl.push_back('{M_U,       24'h000050, 3'd3});

    kn  = '1;
    rst = 1'b1;
    tick(2);
    chk_reset_vals("rst");
    chk("rst_cursor", 32'(dut.cursor_q), 32'h0);
    rst = 1'b0;

    // Idle display shows zeros
    tick(3);
    chk("idle_led", 32'(led), 32'hC0);

    // Short press is rejected, long press enters SET right after release
    press(M_E, 3);
    chk("short_ke_state", 32'(dut.state_q), 32'(IDLE));
    press(M_E, 6);
    chk("long_ke_state", 32'(dut.state_q), 32'(SET));

    foreach (tbl[i]) begin
      sb.push_back('{tbl[i].value, tbl[i].cursor});
      press(tbl[i].keys, DB);
      e = sb.pop_front();
      chk($sformatf("vec%0d_value", i), 32'(value), 32'(e.value));
      chk($sformatf("vec%0d_cursor", i), 32'(dut.cursor_q), 32'(e.cursor));
      chk($sformatf("vec%0d_state", i), 32'(dut.state_q), 32'(SET));
    end
    press(M_E, DB);
    chk("set_to_run", 32'(dut.state_q), 32'(RUN));

    // Countdown from 000100 to zero
    do_reset();
    press(M_E, DB);
    press(M_L, DB);
    press(M_L, DB);
    press(M_U, DB);
    chk("cd_load", 32'(value), 32'h000100);
    press(M_E, DB);
    chk("cd_run", 32'(dut.state_q), 32'(RUN));
    tick(TC - 1);
    chk("cd_before_tick", 32'(value), 32'h000100);
    tick(1);
    chk("cd_borrow", 32'(value), 32'h000059);
    tick(59 * TC - 1);
    chk("cd_one", 32'(value), 32'h000001);
    chk("cd_one_state", 32'(dut.state_q), 32'(RUN));
    chk("cd_one_alarm", 32'(alarm), 32'h1);
    tick(1);
    chk("cd_zero", 32'(value), 32'h0);
    chk("cd_done", 32'(dut.state_q), 32'(DONE));
    chk("cd_alarm", 32'(alarm), 32'h0);

    // DONE display scan: d on digit 1, n on 2, E on 3, blank elsewhere
    seen = '0;
    for (int c = 0; c < 2 * SD * ND + 6; c++) begin
      tick(1);
      chk("sel_onehot0", 32'($countones(~sel) <= 1), 32'h1);
      if (sel != '1) begin
        id = 0;
        for (int j = 0; j < ND; j++) if (!sel[j]) id = j;
        seen[id] = 1'b1;
        case (id)
          1: el = 8'hA1;
          2: el = 8'hAB;
          3: el = 8'h86;
          default: el = 8'hFF;
        endcase
        chk($sformatf("done_led_d%0d", id), 32'(led), 32'(el));
      end
    end
    chk("scan_cover", 32'(seen), 32'h3F);
    press(M_E, DB);
    chk("done_idle", 32'(dut.state_q), 32'(IDLE));
    chk("done_idle_alarm", 32'(alarm), 32'h1);
    chk("done_idle_value", 32'(value), 32'h0);

    // Zero value goes straight to DONE
    press(M_E, DB);
    press(M_E, DB);
    chk("zero_done", 32'(dut.state_q), 32'(DONE));
    chk("zero_alarm", 32'(alarm), 32'h0);
    press(M_E, DB);

    // RUN with value 2: ku handling and abort
    press(M_E, DB);
    press(M_U, DB);
    press(M_U, DB);
    press(M_E, DB);
    chk("ab_run", 32'(dut.state_q), 32'(RUN));
    press(M_U, DB);
`ifdef CNTDN_PAUSE_EN
    tick(30);
    chk("pause_hold", 32'(value), 32'h000002);
    press(M_U, DB);
    press(M_E, DB);
    chk("ab_done", 32'(dut.state_q), 32'(DONE));
    chk("ab_value", 32'(value), 32'h000002);
`else
    chk("ku_ignored", 32'(value), 32'h000002);
    tick(TC - DB - 1);
    chk("ab_dec", 32'(value), 32'h000001);
    press(M_E, DB);
    chk("ab_done", 32'(dut.state_q), 32'(DONE));
    chk("ab_value", 32'(value), 32'h000001);
`endif

    // Reset in the middle of RUN
    do_reset();
    press(M_E, DB);
    press(M_U, DB);
    press(M_E, DB);
    tick(3);
    chk("mid_run", 32'(dut.state_q), 32'(RUN));
    do_reset();
    chk_reset_vals("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
